// File: rtl/pwm_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_sequencer_if
// Description : Link between the PWM sequencer and the PWM generator:
//               compare value and counter-enable tick going downstream,
//               period-start pulse coming back upstream.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_sequencer_if #(
   parameter int COUNTER_WIDTH = 10
);
   logic                     pwm_set_o;
   logic [COUNTER_WIDTH-1:0] cmp_value_o;
   logic                     period_start_i;

   // Sequencer side
   modport master (
      output pwm_set_o,
      output cmp_value_o,
      input  period_start_i
   );

   // PWM generator side
   modport slave (
      input  pwm_set_o,
      input  cmp_value_o,
      output period_start_i
   );
endinterface
`default_nettype wire

// File: rtl/pwm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pwm_sequencer
// Description : Plays a programmable sequence of duty values into a PWM
//               generator. Each pattern entry is held for hold+1 PWM periods,
//               the sequence runs once or loops, and an internal prescaler
//               produces the PWM counter-enable tick.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_sequencer #(
   parameter int  COUNTER_WIDTH  = 10,
   parameter int  DEPTH          = 8,
   parameter int  PRESCALE_WIDTH = 8,
   parameter int  HOLD_WIDTH     = 4,
   localparam int IDX_W          = $clog2(DEPTH)
) (
   input  wire logic                      clk,
   input  wire logic                      rst,
   input  wire logic                      wr_en_i,
   input  wire logic [IDX_W-1:0]          wr_addr_i,
   input  wire logic [COUNTER_WIDTH-1:0]  wr_data_i,
   input  wire logic [PRESCALE_WIDTH-1:0] prescale_i,
   input  wire logic [IDX_W-1:0]          seq_last_i,
   input  wire logic [HOLD_WIDTH-1:0]     hold_i,
   input  wire logic                      repeat_i,
   input  wire logic                      start_i,
   input  wire logic                      stop_i,
   pwm_sequencer_if.master                pwm,
   output logic                           busy_o,
   output logic                           done_o
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic [IDX_W-1:0]          c_idx_first = '0;
   localparam logic [IDX_W-1:0]          c_idx_one   = IDX_W'(1);
   localparam logic [HOLD_WIDTH-1:0]     c_hold_one  = HOLD_WIDTH'(1);
   localparam logic [PRESCALE_WIDTH-1:0] c_pre_one   = PRESCALE_WIDTH'(1);

   state_t                    r_state;
   logic [COUNTER_WIDTH-1:0]  r_mem [DEPTH];
   logic [IDX_W-1:0]          r_last;
   logic [HOLD_WIDTH-1:0]     r_hold;
   logic                      r_repeat;
   logic [PRESCALE_WIDTH-1:0] r_prescale;
   logic [IDX_W-1:0]          r_idx;
   logic [HOLD_WIDTH-1:0]     r_hold_cnt;
   logic [PRESCALE_WIDTH-1:0] r_pre_cnt;
   logic [COUNTER_WIDTH-1:0]  r_cmp;
   logic                      r_set;
   logic                      r_done;

   logic [IDX_W-1:0]          w_idx_next;
   logic [PRESCALE_WIDTH-1:0] w_pre_next;

   // Next entry index (wraps naturally when the last index is DEPTH-1) and
   // next prescaler count (returns to zero once the divider value is reached).
   always_comb begin
      w_idx_next = r_idx + c_idx_one;
      w_pre_next = (r_pre_cnt == r_prescale) ? '0 : (r_pre_cnt + c_pre_one);
   end

   // Pattern memory: writable in any state; a running entry keeps its value
   // on cmp_value_o until it is loaded again.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (wr_en_i) begin
         r_mem[wr_addr_i] <= wr_data_i;
      end
   end

   // Sequencer FSM with prescaler, hold counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_last     <= '0;
         r_hold     <= '0;
         r_repeat   <= 1'b0;
         r_prescale <= '0;
         r_idx      <= '0;
         r_hold_cnt <= '0;
         r_pre_cnt  <= '0;
         r_cmp      <= '0;
         r_set      <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cmp <= '0;
               r_set <= 1'b0;
               if (start_i && !stop_i) begin
                  r_state    <= S_RUN;
                  r_last     <= seq_last_i;
                  r_hold     <= hold_i;
                  r_repeat   <= repeat_i;
                  r_prescale <= prescale_i;
                  r_idx      <= c_idx_first;
                  r_hold_cnt <= '0;
                  r_pre_cnt  <= '0;
                  r_cmp      <= r_mem[c_idx_first];
                  // A divider of zero ticks on every RUN cycle, including the first.
                  r_set      <= (prescale_i == '0);
               end
            end

            S_RUN: begin
               r_pre_cnt <= w_pre_next;
               r_set     <= (w_pre_next == r_prescale);
               if (stop_i) begin
                  // Abort wins over a same-cycle period boundary.
                  r_state <= S_IDLE;
                  r_cmp   <= '0;
                  r_set   <= 1'b0;
               end else if (pwm.period_start_i) begin
                  if (r_hold_cnt < r_hold) begin
                     r_hold_cnt <= r_hold_cnt + c_hold_one;
                  end else begin
                     r_hold_cnt <= '0;
                     if (r_idx != r_last) begin
                        r_idx <= w_idx_next;
                        r_cmp <= r_mem[w_idx_next];
                     end else if (r_repeat) begin
                        r_idx <= c_idx_first;
                        r_cmp <= r_mem[c_idx_first];
                     end else begin
                        r_state <= S_IDLE;
                        r_cmp   <= '0;
                        r_set   <= 1'b0;
                        r_done  <= 1'b1;
                     end
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_cmp   <= '0;
               r_set   <= 1'b0;
            end
         endcase
      end
   end

   assign pwm.pwm_set_o   = r_set;
   assign pwm.cmp_value_o = r_cmp;
   assign busy_o          = (r_state == S_RUN);
   assign done_o          = r_done;

endmodule
`default_nettype wire
